clock_time_ctrl: RTL and testbench

//  Sequencer for the digital-clock BCD counter chain: sec (x10 + x6), min (x10 + x6), hour (x10 + x10).

---
 rtl/clock_pkg.sv | 19 +
 rtl/clock_carry_gen.sv | 33 +++
 rtl/clock_time_ctrl.sv | 167 ++++++++++++++++
 tb/tb_clock_time_ctrl.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared definitions for the digital-clock blocks: mode encodings and BCD digit limits.
package clock_pkg;

    typedef enum logic [1:0] {
        MODE_RUN     = 2'd0,
        MODE_SET_HR  = 2'd1,
        MODE_SET_MIN = 2'd2
    } mode_t;

    localparam logic [3:0] DIG10_MAX = 4'd9;
    localparam logic [3:0] DIG6_MAX  = 4'd5;

    // True when a two-digit BCD field sits exactly at the given limit.
    function automatic logic at_limit(input logic [3:0] hi, input logic [3:0] lo,
                                      input logic [3:0] hi_max, input logic [3:0] lo_max);
        return (hi == hi_max) && (lo == lo_max);
    endfunction

endpackage

// File: rtl/clock_carry_gen.sv
// Ripple-carry detection for the sec/min/hour digit chain. Exact compares only,
// so out-of-range digits simply never produce a carry.
module clock_carry_gen
    import clock_pkg::*;
#(
    parameter logic [3:0] HR_MAX_HI = 4'd2,
    parameter logic [3:0] HR_MAX_LO = 4'd3
) (
    input  logic [3:0] sec_lo,
    input  logic [3:0] sec_hi,
    input  logic [3:0] min_lo,
    input  logic [3:0] min_hi,
    input  logic [3:0] hr_lo,
    input  logic [3:0] hr_hi,
    output logic       sec_full,
    output logic       min_full,
    output logic       hr_full,
    output logic       sec_lo9,
    output logic       min_lo9,
    output logic       hr_lo9
);

    // Terminal-value decodes for each digit pair.
    always_comb begin
        sec_full = at_limit(sec_hi, sec_lo, DIG6_MAX, DIG10_MAX);
        min_full = at_limit(min_hi, min_lo, DIG6_MAX, DIG10_MAX);
        hr_full  = at_limit(hr_hi, hr_lo, HR_MAX_HI, HR_MAX_LO);
        sec_lo9  = (sec_lo == DIG10_MAX);
        min_lo9  = (min_lo == DIG10_MAX);
        hr_lo9   = (hr_lo == DIG10_MAX);
    end

endmodule

// File: rtl/clock_time_ctrl.sv
// Digital-clock sequencer: per-digit count enables, hour wrap clear and the
// RUN/SET_HR/SET_MIN time-setting FSM. All outputs are registered.
//
//  state         | meaning
//  --------------+-------------------------------------------------------------
//  MODE_RUN      | time advances on tick; key_inc ignored
//  MODE_SET_HR   | time frozen; key_inc steps the hour; blink_hr toggles on tick
//  MODE_SET_MIN  | time frozen; key_inc steps the minute; blink_min toggles on tick
module clock_time_ctrl
    import clock_pkg::*;
#(
    parameter logic [3:0] HR_MAX_HI = 4'd2,
    parameter logic [3:0] HR_MAX_LO = 4'd3
) (
    input  logic       CP,
    input  logic       CLR,
    input  logic       tick,
    input  logic       key_mode,
    input  logic       key_inc,
    input  logic [3:0] sec_lo,
    input  logic [3:0] sec_hi,
    input  logic [3:0] min_lo,
    input  logic [3:0] min_hi,
    input  logic [3:0] hr_lo,
    input  logic [3:0] hr_hi,
    output logic       en_sec_lo,
    output logic       en_sec_hi,
    output logic       en_min_lo,
    output logic       en_min_hi,
    output logic       en_hr_lo,
    output logic       en_hr_hi,
    output logic       sec_clr,
    output logic       hr_clr,
    output logic [1:0] mode,
    output logic       blink_hr,
    output logic       blink_min
);

    mode_t state_q, state_d;

    logic sec_full, min_full, hr_full;
    logic sec_lo9, min_lo9, hr_lo9;

    logic en_sec_lo_d, en_sec_hi_d, en_min_lo_d, en_min_hi_d, en_hr_lo_d, en_hr_hi_d;
    logic sec_clr_d, hr_clr_d, blink_hr_d, blink_min_d;
    logic hr_carry, inc_ok;

    clock_carry_gen #(
        .HR_MAX_HI (HR_MAX_HI),
        .HR_MAX_LO (HR_MAX_LO)
    ) u_carry (
        .sec_lo   (sec_lo),
        .sec_hi   (sec_hi),
        .min_lo   (min_lo),
        .min_hi   (min_hi),
        .hr_lo    (hr_lo),
        .hr_hi    (hr_hi),
        .sec_full (sec_full),
        .min_full (min_full),
        .hr_full  (hr_full),
        .sec_lo9  (sec_lo9),
        .min_lo9  (min_lo9),
        .hr_lo9   (hr_lo9)
    );

    // Mode state register.
    always_ff @(posedge CP) begin
        if (CLR) state_q <= MODE_RUN;
        else     state_q <= state_d;
    end

    // Next mode, enable/clear pulses and blink toggles.
    always_comb begin
        state_d     = state_q;
        en_sec_lo_d = 1'b0;
        en_sec_hi_d = 1'b0;
        en_min_lo_d = 1'b0;
        en_min_hi_d = 1'b0;
        en_hr_lo_d  = 1'b0;
        en_hr_hi_d  = 1'b0;
        sec_clr_d   = 1'b0;
        hr_clr_d    = 1'b0;
        blink_hr_d  = 1'b0;
        blink_min_d = 1'b0;
        hr_carry    = sec_full && min_full;
        // A simultaneous mode press wins over the increment key.
        inc_ok      = key_inc && !key_mode;

        case (state_q)
            MODE_RUN: begin
                if (key_mode) state_d = MODE_SET_HR;
                if (tick) begin
                    en_sec_lo_d = 1'b1;
                    en_sec_hi_d = sec_lo9;
                    en_min_lo_d = sec_full;
                    en_min_hi_d = sec_full && min_lo9;
                    if (hr_carry && hr_full) begin
                        hr_clr_d = 1'b1;
                    end else begin
                        en_hr_lo_d = hr_carry;
                        en_hr_hi_d = hr_carry && hr_lo9;
                    end
                end
            end
            MODE_SET_HR: begin
                if (key_mode) state_d = MODE_SET_MIN;
                blink_hr_d = blink_hr ^ tick;
                if (inc_ok) begin
                    if (hr_full) begin
                        hr_clr_d = 1'b1;
                    end else begin
                        en_hr_lo_d = 1'b1;
                        en_hr_hi_d = hr_lo9;
                    end
                end
            end
            MODE_SET_MIN: begin
                if (key_mode) begin
                    state_d   = MODE_RUN;
                    sec_clr_d = 1'b1;
                end
                blink_min_d = blink_min ^ tick;
                // Digit counters wrap 59 -> 00 themselves; no hour carry here.
                if (inc_ok) begin
                    en_min_lo_d = 1'b1;
                    en_min_hi_d = min_lo9;
                end
            end
            default: state_d = MODE_RUN;
        endcase

        if (state_d != state_q) begin
            blink_hr_d  = 1'b0;
            blink_min_d = 1'b0;
        end
    end

    // Output registers; reset drops any pending pulse.
    always_ff @(posedge CP) begin
        if (CLR) begin
            en_sec_lo <= 1'b0;
            en_sec_hi <= 1'b0;
            en_min_lo <= 1'b0;
            en_min_hi <= 1'b0;
            en_hr_lo  <= 1'b0;
            en_hr_hi  <= 1'b0;
            sec_clr   <= 1'b0;
            hr_clr    <= 1'b0;
            blink_hr  <= 1'b0;
            blink_min <= 1'b0;
        end else begin
            en_sec_lo <= en_sec_lo_d;
            en_sec_hi <= en_sec_hi_d;
            en_min_lo <= en_min_lo_d;
            en_min_hi <= en_min_hi_d;
            en_hr_lo  <= en_hr_lo_d;
            en_hr_hi  <= en_hr_hi_d;
            sec_clr   <= sec_clr_d;
            hr_clr    <= hr_clr_d;
            blink_hr  <= blink_hr_d;
            blink_min <= blink_min_d;
        end
    end

    assign mode = state_q;

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Directed-vector bench for clock_time_ctrl. Pulse outputs are packed as
// {en_sec_lo, en_sec_hi, en_min_lo, en_min_hi, en_hr_lo, en_hr_hi, sec_clr, hr_clr}.
module tb_clock_time_ctrl;

    logic       CP, CLR, tick, key_mode, key_inc;
    logic [3:0] sec_lo, sec_hi, min_lo, min_hi, hr_lo, hr_hi;
    logic       en_sec_lo, en_sec_hi, en_min_lo, en_min_hi, en_hr_lo, en_hr_hi;
    logic       sec_clr, hr_clr, blink_hr, blink_min;
    logic [1:0] mode;

    int n_vec = 0;
    int n_bad = 0;

    clock_time_ctrl dut (
        .CP        (CP),
        .CLR       (CLR),
        .tick      (tick),
        .key_mode  (key_mode),
        .key_inc   (key_inc),
        .sec_lo    (sec_lo),
        .sec_hi    (sec_hi),
        .min_lo    (min_lo),
        .min_hi    (min_hi),
        .hr_lo     (hr_lo),
        .hr_hi     (hr_hi),
        .en_sec_lo (en_sec_lo),
        .en_sec_hi (en_sec_hi),
        .en_min_lo (en_min_lo),
        .en_min_hi (en_min_hi),
        .en_hr_lo  (en_hr_lo),
        .en_hr_hi  (en_hr_hi),
        .sec_clr   (sec_clr),
        .hr_clr    (hr_clr),
        .mode      (mode),
        .blink_hr  (blink_hr),
        .blink_min (blink_min)
    );

    initial CP = 1'b0;
    always #5 CP = ~CP;

    function automatic logic [7:0] pulses();
        return {en_sec_lo, en_sec_hi, en_min_lo, en_min_hi, en_hr_lo, en_hr_hi, sec_clr, hr_clr};
    endfunction

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Digits given as packed BCD, e.g. 8'h23.
    task automatic set_time(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        {hr_hi, hr_lo}   = h;
        {min_hi, min_lo} = m;
        {sec_hi, sec_lo} = s;
    endtask

    // Called at a negedge: drive pulses for one posedge, return at the next negedge.
    task automatic step(input logic t, input logic km, input logic ki);
        tick = t; key_mode = km; key_inc = ki;
        @(posedge CP);
        @(negedge CP);
        tick = 1'b0; key_mode = 1'b0; key_inc = 1'b0;
    endtask

    // Outputs after a step: pulse vector, mode and both blink bits.
    task automatic expect_all(input string tag, input logic [7:0] p, input logic [1:0] m,
                              input logic bh, input logic bm);
        check_eq({tag, ".pulse"}, pulses(), p);
        check_eq({tag, ".mode"}, {6'd0, mode}, {6'd0, m});
        check_eq({tag, ".blink"}, {6'd0, blink_hr, blink_min}, {6'd0, bh, bm});
    endtask

    task automatic randomize_inputs();
        tick = 1'($urandom); key_mode = 1'($urandom); key_inc = 1'($urandom);
        sec_lo = 4'($urandom); sec_hi = 4'($urandom); min_lo = 4'($urandom);
        min_hi = 4'($urandom); hr_lo = 4'($urandom); hr_hi = 4'($urandom);
    endtask

    initial begin
        // 1. reset held two cycles with random inputs
        CLR = 1'b1;
        randomize_inputs();
        @(posedge CP); @(negedge CP);
        randomize_inputs();
        @(posedge CP); @(negedge CP);
        expect_all("reset", 8'b0000_0000, 2'd0, 1'b0, 1'b0);
        CLR = 1'b0;
        tick = 1'b0; key_mode = 1'b0; key_inc = 1'b0;
        set_time(8'h00, 8'h00, 8'h00);
        step(1'b0, 1'b0, 1'b0);
        expect_all("idle", 8'b0000_0000, 2'd0, 1'b0, 1'b0);

        // 2-4. RUN tick carries
        set_time(8'h00, 8'h00, 8'h09); step(1'b1, 1'b0, 1'b0);
        expect_all("run_00_00_09", 8'b1100_0000, 2'd0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check_eq("pulse_one_cycle", pulses(), 8'b0000_0000);
        set_time(8'h00, 8'h00, 8'h05); step(1'b1, 1'b0, 1'b0);
        check_eq("run_00_00_05", pulses(), 8'b1000_0000);
        set_time(8'h00, 8'h09, 8'h59); step(1'b1, 1'b0, 1'b0);
        check_eq("run_00_09_59", pulses(), 8'b1111_0000);
        set_time(8'h00, 8'h59, 8'h59); step(1'b1, 1'b0, 1'b0);
        check_eq("run_00_59_59", pulses(), 8'b1111_1000);
        set_time(8'h19, 8'h59, 8'h59); step(1'b1, 1'b0, 1'b0);
        check_eq("run_19_59_59", pulses(), 8'b1111_1100);
        set_time(8'h23, 8'h59, 8'h59); step(1'b1, 1'b0, 1'b0);
        check_eq("run_23_59_59", pulses(), 8'b1111_0001);
        set_time(8'h13, 8'h59, 8'h59); step(1'b1, 1'b0, 1'b0);
        check_eq("run_13_59_59", pulses(), 8'b1111_1000);
        set_time(8'h00, 8'h59, 8'h5C); step(1'b1, 1'b0, 1'b0);
        check_eq("run_out_of_range", pulses(), 8'b1000_0000);
        set_time(8'h00, 8'h00, 8'h09); step(1'b0, 1'b0, 1'b1);
        expect_all("run_inc_ignored", 8'b0000_0000, 2'd0, 1'b0, 1'b0);

        // 5. SET_HR
        step(1'b0, 1'b1, 1'b0);
        expect_all("to_set_hr", 8'b0000_0000, 2'd1, 1'b0, 1'b0);
        set_time(8'h19, 8'h00, 8'h09); step(1'b0, 1'b0, 1'b1);
        check_eq("set_hr_19", pulses(), 8'b0000_1100);
        set_time(8'h14, 8'h00, 8'h00); step(1'b0, 1'b0, 1'b1);
        check_eq("set_hr_14", pulses(), 8'b0000_1000);
        set_time(8'h23, 8'h00, 8'h00); step(1'b0, 1'b0, 1'b1);
        check_eq("set_hr_23", pulses(), 8'b0000_0001);
        set_time(8'h19, 8'h59, 8'h59); step(1'b1, 1'b0, 1'b0);
        expect_all("set_hr_tick1", 8'b0000_0000, 2'd1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        expect_all("set_hr_tick2", 8'b0000_0000, 2'd1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        expect_all("set_hr_tick3", 8'b0000_0000, 2'd1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        expect_all("set_hr_hold", 8'b0000_0000, 2'd1, 1'b1, 1'b0);

        // 6. SET_MIN
        step(1'b0, 1'b1, 1'b0);
        expect_all("to_set_min", 8'b0000_0000, 2'd2, 1'b0, 1'b0);
        set_time(8'h23, 8'h59, 8'h30); step(1'b0, 1'b0, 1'b1);
        check_eq("set_min_59", pulses(), 8'b0011_0000);
        set_time(8'h23, 8'h45, 8'h30); step(1'b0, 1'b0, 1'b1);
        check_eq("set_min_45", pulses(), 8'b0010_0000);
        step(1'b1, 1'b0, 1'b0);
        expect_all("set_min_tick", 8'b0000_0000, 2'd2, 1'b0, 1'b1);
        set_time(8'h23, 8'h59, 8'h59); step(1'b0, 1'b1, 1'b1);
        expect_all("set_min_exit", 8'b0000_0010, 2'd0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check_eq("sec_clr_once", pulses(), 8'b0000_0000);

        // Reset mid-operation drops a pending pulse and returns to RUN.
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        expect_all("pre_clr", 8'b0000_0000, 2'd1, 1'b1, 1'b0);
        set_time(8'h19, 8'h00, 8'h00);
        CLR = 1'b1;
        step(1'b0, 1'b0, 1'b1);
        CLR = 1'b0;
        expect_all("mid_clr", 8'b0000_0000, 2'd0, 1'b0, 1'b0);
        set_time(8'h00, 8'h00, 8'h09); step(1'b1, 1'b0, 1'b0);
        check_eq("after_clr_run", pulses(), 8'b1100_0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
